execute_iter: RTL and testbench



---
 rtl/execute_iter.sv | 244 ++++++++++++++++++++++++
 tb/tb_execute_iter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_iter.sv
// execute_iter: handshaked execute stage between decode and memory.
// Operands come through an N-way forwarding mux and are captured on accept.
// ADD/SUB/AND/XOR finish in one cycle. MUL (shift-add) and DIVU (restoring)
// iterate one bit per cycle. The result register holds until memory takes it.
// Build option: define EXECUTE_ITER_DIV_EN to include the iterative divider.
// Without it, op 110 is treated as a reserved single-cycle op.
module execute_iter #(
  parameter  int WIDTH   = 16,
  parameter  int FW_SRCS = 4,
  localparam int FSW     = $clog2(FW_SRCS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         inA,
  input  logic [WIDTH-1:0]         inB,
  input  logic [FSW-1:0]           fwSelA,
  input  logic [FSW-1:0]           fwSelB,
  input  logic [FW_SRCS*WIDTH-1:0] fwData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         resultHi,
  output logic                     zeroFlag,
  output logic                     signFlag,
  output logic                     carryOut,
  output logic                     oflFlag,
  output logic                     busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // MUL: partial product high / DIVU: remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // MUL: multiplier shifting out / DIVU: dividend -> quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic             ofl_q, ofl_d;
`ifdef EXECUTE_ITER_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   div_trial;
`endif

  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             start_iter;
  logic             accept;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign accept    = in_valid && in_ready;

  assign result   = result_q;
  assign resultHi = result_hi_q;
  assign zeroFlag = zero_q;
  assign signFlag = sign_q;
  assign carryOut = carry_q;
  assign oflFlag  = ofl_q;

`ifdef EXECUTE_ITER_DIV_EN
  assign start_iter = (op == OP_MUL) || (op == OP_DIVU);
`else
  assign start_iter = (op == OP_MUL);
`endif

  // Forwarding mux: select 0 or any out-of-range select falls back to the register file.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fwd_a = inA;
    fwd_b = inB;
    for (int k = 1; k <= FW_SRCS; k++) begin
      if (fwSelA == FSW'(k)) fwd_a = fwData[(k-1)*WIDTH +: WIDTH];
      if (fwSelB == FSW'(k)) fwd_b = fwData[(k-1)*WIDTH +: WIDTH];
    end
  end

  // Single-cycle ALU on the forwarded operands; reserved and iterative codes yield 0 here.
  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op)
      OP_ADD: begin
        sum_ext = {1'b0, fwd_a} + {1'b0, fwd_b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_o   = (fwd_a[WIDTH-1] == fwd_b[WIDTH-1]) && (alu_res[WIDTH-1] != fwd_a[WIDTH-1]);
      end
      OP_SUB: begin
        // A + ~B + 1, so carry set means no borrow.
        sum_ext = {1'b0, fwd_a} + {1'b0, ~fwd_b} + (WIDTH+1)'(1);
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_o   = (fwd_a[WIDTH-1] != fwd_b[WIDTH-1]) && (alu_res[WIDTH-1] != fwd_a[WIDTH-1]);
      end
      OP_AND:  alu_res = fwd_a & fwd_b;
      OP_XOR:  alu_res = fwd_a ^ fwd_b;
      default: alu_res = '0;
    endcase
  end

  // One iteration step: shift-add multiply, or one restoring-division quotient bit.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef EXECUTE_ITER_DIV_EN
    // Partial remainder stays below the divisor, so bit WIDTH of the trial is its sign.
    // A zero divisor never borrows: quotient fills with ones and the remainder collects A.
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Next-state logic for the IDLE/CALC/DONE controller and the datapath registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    sign_d      = sign_q;
    carry_d     = carry_q;
    ofl_d       = ofl_q;
`ifdef EXECUTE_ITER_DIV_EN
    is_div_d    = is_div_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          b_d = fwd_b;
          if (start_iter) begin
            state_d  = S_CALC;
            cnt_d    = CW'(WIDTH - 1);
            acc_hi_d = '0;
            acc_lo_d = fwd_a;
`ifdef EXECUTE_ITER_DIV_EN
            is_div_d = (op == OP_DIVU);
`endif
          end else begin
            state_d     = S_DONE;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            sign_d      = alu_res[WIDTH-1];
            carry_d     = alu_c;
            ofl_d       = alu_o;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == '0) begin
          // Last bit processed this cycle: publish {resultHi, result}.
          state_d     = S_DONE;
          result_d    = step_lo;
          result_hi_d = step_hi;
          zero_d      = (step_lo == '0);
          sign_d      = step_lo[WIDTH-1];
          carry_d     = 1'b0;
          ofl_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      ofl_q       <= 1'b0;
`ifdef EXECUTE_ITER_DIV_EN
      is_div_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      carry_q     <= carry_d;
      ofl_q       <= ofl_d;
`ifdef EXECUTE_ITER_DIV_EN
      is_div_q    <= is_div_d;
`endif
    end
  end

endmodule

// File: tb/tb_execute_iter.sv
// Testbench for execute_iter (WIDTH=16, FW_SRCS=4): vector table through a
// scoreboard queue, plus backpressure and mid-operation reset sequences.
// DIVU expectations follow whether EXECUTE_ITER_DIV_EN is defined.
module tb_execute_iter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int FSW = $clog2(N + 1);

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, XOR_ = 3'b011;
  localparam logic [2:0] MUL = 3'b100, RSV5 = 3'b101, DIVU = 3'b110, RSV7 = 3'b111;

  // slice0=9999 slice1=1234 slice2=5555 slice3=AAAA
  localparam logic [N*W-1:0] FW0 = 64'hAAAA_5555_1234_9999;
  localparam logic [N*W-1:0] FW1 = 64'h0100_5555_1234_FFFF;

  logic           clk, rst;
  logic           in_valid, in_ready;
  logic [2:0]     op;
  logic [W-1:0]   inA, inB;
  logic [FSW-1:0] fwSelA, fwSelB;
  logic [N*W-1:0] fwData;
  logic           out_valid, out_ready;
  logic [W-1:0]   result, resultHi;
  logic           zeroFlag, signFlag, carryOut, oflFlag, busy;

  execute_iter #(.WIDTH(W), .FW_SRCS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .inA(inA), .inB(inB), .fwSelA(fwSelA), .fwSelB(fwSelB), .fwData(fwData),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .resultHi(resultHi),
    .zeroFlag(zeroFlag), .signFlag(signFlag), .carryOut(carryOut), .oflFlag(oflFlag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic [FSW-1:0] sel_a, sel_b;
    logic [N*W-1:0] fw;
    logic [W-1:0]   res, hi;
    logic [3:0]     flg;   // {zero, sign, carry, ofl}
    int             lat;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res, hi;
    logic [3:0]   flg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] o,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [FSW-1:0] sa, input logic [FSW-1:0] sbs,
                              input logic [N*W-1:0] fw, input logic [W-1:0] res,
                              input logic [W-1:0] hi, input logic [3:0] flg, input int lat);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b; v.sel_a = sa; v.sel_b = sbs;
    v.fw = fw; v.res = res; v.hi = hi; v.flg = flg; v.lat = lat;
    return v;
  endfunction

  task automatic push_exp(input string name, input logic [W-1:0] res,
                          input logic [W-1:0] hi, input logic [3:0] flg);
    exp_t e;
    e.name = name; e.res = res; e.hi = hi; e.flg = flg;
    sb.push_back(e);
  endtask

  // Scoreboard: every result handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb.unexpected: got result=%h with nothing expected", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".result"},   64'(result),   64'(mon_e.res));
        check({mon_e.name, ".resultHi"}, 64'(resultHi), 64'(mon_e.hi));
        check({mon_e.name, ".flags"},    64'({zeroFlag, signFlag, carryOut, oflFlag}), 64'(mon_e.flg));
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; op = o; inA = a; inB = b;
    fwSelA = '0; fwSelB = '0; fwData = FW0;
  endtask

  // Offer one op, wait for accept, scramble inputs, then measure latency and busy cycles.
  task automatic issue(input vec_t v);
    bit acc = 0;
    bit got = 0;
    int lat = 0;
    int busy_n = 0;
    in_valid = 1'b1; op = v.op; inA = v.a; inB = v.b;
    fwSelA = v.sel_a; fwSelB = v.sel_b; fwData = v.fw;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
    end
    if (!acc) begin
      check({v.name, ".accept_timeout"}, 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    push_exp(v.name, v.res, v.hi, v.flg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); inA = W'($urandom); inB = W'($urandom);
    fwSelA = FSW'($urandom); fwSelB = FSW'($urandom); fwData = {$urandom, $urandom};
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; got = 1; break; end
      if (busy && !in_ready) busy_n++;
    end
    check({v.name, ".latency"}, 64'(lat), 64'(v.lat));
    check({v.name, ".busy_cycles"}, 64'(busy_n), 64'(got ? v.lat - 1 : -1));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 0; rst = 0; in_valid = 0; out_ready = 1; op = '0;
    inA = '0; inB = '0; fwSelA = '0; fwSelB = '0; fwData = '0;

    // Vector table: {name, op, a, b, selA, selB, fwData, result, resultHi, {z,s,c,o}, latency}
    vecs.push_back(mk("add_ovf",   ADD,  16'h7FFF, 16'h0001, 0, 0, FW0, 16'h8000, 16'h0000, 4'b0101, 1));
    vecs.push_back(mk("sub_borrow",SUB,  16'h0003, 16'h0005, 0, 0, FW0, 16'hFFFE, 16'h0000, 4'b0100, 1));
    vecs.push_back(mk("xor_fwd2",  XOR_, 16'hFFFF, 16'h00FF, 2, 0, FW0, 16'h12CB, 16'h0000, 4'b0000, 1));
    vecs.push_back(mk("xor_sel7",  XOR_, 16'h0F0F, 16'h00FF, 7, 0, FW0, 16'h0FF0, 16'h0000, 4'b0000, 1));
    vecs.push_back(mk("add_sel56", ADD,  16'h0011, 16'h0022, 5, 6, FW0, 16'h0033, 16'h0000, 4'b0000, 1));
    vecs.push_back(mk("add_fw31",  ADD,  16'h0000, 16'h0000, 3, 1, FW0, 16'hEEEE, 16'h0000, 4'b0100, 1));
    vecs.push_back(mk("add_fwB4",  ADD,  16'h0001, 16'hDEAD, 0, 4, FW1, 16'h0101, 16'h0000, 4'b0000, 1));
    vecs.push_back(mk("and_zero",  AND_, 16'hF0F0, 16'h0F0F, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1000, 1));
    vecs.push_back(mk("sub_eq",    SUB,  16'h0005, 16'h0005, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1010, 1));
    vecs.push_back(mk("add_wrap",  ADD,  16'hFFFF, 16'h0001, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1010, 1));
    vecs.push_back(mk("sub_ovf",   SUB,  16'h8000, 16'h0001, 0, 0, FW0, 16'h7FFF, 16'h0000, 4'b0011, 1));
    vecs.push_back(mk("rsv5",      RSV5, 16'h0001, 16'h0002, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1000, 1));
    vecs.push_back(mk("rsv7",      RSV7, 16'hFFFF, 16'hFFFF, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1000, 1));
    vecs.push_back(mk("mul_small", MUL,  16'h0123, 16'h0010, 0, 0, FW0, 16'h1230, 16'h0000, 4'b0000, 17));
    vecs.push_back(mk("mul_max",   MUL,  16'h0000, 16'hFFFF, 1, 0, FW1, 16'h0001, 16'hFFFE, 4'b0000, 17));
    vecs.push_back(mk("mul_hi",    MUL,  16'h8000, 16'h0002, 0, 0, FW0, 16'h0000, 16'h0001, 4'b1000, 17));
    vecs.push_back(mk("mul_ffff",  MUL,  16'h00FF, 16'h0101, 0, 0, FW0, 16'hFFFF, 16'h0000, 4'b0100, 17));
`ifdef EXECUTE_ITER_DIV_EN
    vecs.push_back(mk("div_100_7", DIVU, 16'h0064, 16'h0007, 0, 0, FW0, 16'h000E, 16'h0002, 4'b0000, 17));
    vecs.push_back(mk("div_by0",   DIVU, 16'h0005, 16'h0000, 0, 0, FW0, 16'hFFFF, 16'h0005, 4'b0100, 17));
    vecs.push_back(mk("div_big",   DIVU, 16'hFFFF, 16'h0010, 0, 0, FW0, 16'h0FFF, 16'h000F, 4'b0000, 17));
    vecs.push_back(mk("div_small", DIVU, 16'h0003, 16'h0007, 0, 0, FW0, 16'h0000, 16'h0003, 4'b1000, 17));
`else
    vecs.push_back(mk("div_100_7", DIVU, 16'h0064, 16'h0007, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1000, 1));
    vecs.push_back(mk("div_by0",   DIVU, 16'h0005, 16'h0000, 0, 0, FW0, 16'h0000, 16'h0000, 4'b1000, 1));
`endif

    // Reset state
    #1 rst = 1;
    #2;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.in_ready",  64'(in_ready),  64'(1));
    check("rst.busy",      64'(busy),      64'(0));
    check("rst.result",    64'({resultHi, result}), 64'(0));
    check("rst.flags",     64'({zeroFlag, signFlag, carryOut, oflFlag}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 0;

    foreach (vecs[i]) issue(vecs[i]);

    // Backpressure: hold the ADD result, keep a SUB pending, then release.
    out_ready = 0;
    drive(ADD, 16'h0001, 16'h0002);
    push_exp("bp_add", 16'h0003, 16'h0000, 4'b0000);
    @(negedge clk);
    check("bp.add_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    drive(SUB, 16'h000A, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.hold_valid",  64'(out_valid), 64'(1));
      check("bp.hold_result", 64'(result),    64'(16'h0003));
      check("bp.hold_ready",  64'(in_ready),  64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1;
    push_exp("bp_sub", 16'h0007, 16'h0000, 4'b0010);
    @(negedge clk);
    check("bp.release_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("bp.sub_lat1", 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    // Reset five cycles into a MUL: op abandoned, no result.
    drive(MUL, 16'h0123, 16'h0010);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid.busy_before", 64'(busy), 64'(1));
    rst = 1;
    #1;
    check("rstmid.out_valid", 64'(out_valid), 64'(0));
    check("rstmid.busy",      64'(busy),      64'(0));
    check("rstmid.in_ready",  64'(in_ready),  64'(1));
    check("rstmid.result",    64'(result),    64'(0));
    @(posedge clk); #1;
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid.no_result", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    issue(mk("add_after_rst", ADD, 16'h0002, 16'h0003, 0, 0, FW0, 16'h0005, 16'h0000, 4'b0000, 1));

    repeat (2) @(posedge clk);
    check("sb.empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
